// File: rtl/seq_checker_pkg.sv
// ---------------------------------------------------------------------------
// seq_checker_pkg
// Types, constants and helper functions shared by the sequence checker:
//   state_e      - checker state (HUNT, SYNC, LOCKED)
//   MOD_DEFAULT  - default sequence modulus (generator counts 0..5)
//   seq_inc()    - modulo increment of a 3-bit sequence value
// ---------------------------------------------------------------------------
package seq_checker_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_e;

    localparam int MOD_DEFAULT = 6;

    // Next value in the sequence; anything at or above mod-1 folds back to 0
    // so an out-of-range argument can never produce an out-of-range result.
    function automatic logic [2:0] seq_inc(input logic [2:0] value, input int mod);
        logic [2:0] next_s;
        if (int'(value) >= (mod - 1)) begin
            next_s = 3'd0;
        end else begin
            next_s = value + 3'd1;
        end
        return next_s;
    endfunction

endpackage

// File: rtl/seq_checker_sat.sv
// ---------------------------------------------------------------------------
// sat_counter
// Saturating up-counter with synchronous clear.
//   clk   - clock, rising edge
//   rst   - synchronous active-high reset (count -> 0)
//   clr   - synchronous clear; a simultaneous inc leaves the count at 1
//   inc   - count one event
//   count - current count, sticks at all-ones
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_r;

    // Count register: reset, then clear-then-count, then saturating increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= '0;
        end else if (clr) begin
            count_r <= inc ? W'(1) : '0;
        end else if (inc && (count_r != {W{1'b1}})) begin
            count_r <= count_r + W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/seq_checker.sv
// ---------------------------------------------------------------------------
// seq_checker
// Receive-side checker for the free-running modulo-MOD sequence 0,1,..,MOD-1.
// Hunts for the sequence, locks after LOCK_CNT in-order samples, flags and
// counts mismatches while locked, and drops lock after UNLOCK_ERR
// consecutive mismatches. All outputs are registered (1-cycle latency).
//   clk, rst   - clock / synchronous active-high reset
//   din        - sampled sequence value, qualified by din_valid
//   clr_cnt    - clear the statistics counters
//   locked     - checker is in LOCKED
//   err        - pulse: mismatch while LOCKED
//   wrap       - pulse: matched MOD-1 while LOCKED
//   expected   - value expected on the next valid sample
//   err_count  - saturating mismatch count
// Optional (macro SEQ_CHECKER_STATS_EN):
//   wrap_count - saturating count of wrap pulses
//   lock_loss  - pulse on LOCKED -> HUNT
// ---------------------------------------------------------------------------
module seq_checker
    import seq_checker_pkg::*;
#(
    parameter int MOD        = MOD_DEFAULT,
    parameter int LOCK_CNT   = 3,
    parameter int UNLOCK_ERR = 2,
    parameter int ERRW       = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [2:0]      din,
    input  logic            din_valid,
    input  logic            clr_cnt,
    output logic            locked,
    output logic            err,
    output logic            wrap,
    output logic [2:0]      expected,
    output logic [ERRW-1:0] err_count
`ifdef SEQ_CHECKER_STATS_EN
    ,
    output logic [15:0]     wrap_count,
    output logic            lock_loss
`endif
);

    localparam int RUNW  = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);
    localparam int MISSW = (UNLOCK_ERR < 2) ? 1 : $clog2(UNLOCK_ERR + 1);

    state_e            state_r, state_s;
    logic [2:0]        expected_r, expected_s;
    logic [RUNW-1:0]   run_r, run_s;
    logic [MISSW-1:0]  miss_r, miss_s;
    logic              locked_r, err_r, wrap_r, lock_loss_r;
    logic              err_s, wrap_s, lock_loss_s, legal_s;

    assign legal_s = (int'(din) < MOD);

    // Next-state, next-expected and pulse decode.
    always_comb begin
        state_s     = state_r;
        expected_s  = expected_r;
        run_s       = run_r;
        miss_s      = miss_r;
        err_s       = 1'b0;
        wrap_s      = 1'b0;
        lock_loss_s = 1'b0;
        if (din_valid) begin
            case (state_r)
                HUNT: begin
                    if (legal_s) begin
                        expected_s = seq_inc(din, MOD);
                        run_s      = RUNW'(1);
                        miss_s     = '0;
                        state_s    = (LOCK_CNT == 1) ? LOCKED : SYNC;
                    end else begin
                        state_s = HUNT;
                    end
                end
                SYNC: begin
                    if (din == expected_r) begin
                        expected_s = seq_inc(expected_r, MOD);
                        if ((int'(run_r) + 1) == LOCK_CNT) begin
                            state_s = LOCKED;
                            run_s   = '0;
                            miss_s  = '0;
                        end else begin
                            run_s = run_r + RUNW'(1);
                        end
                    end else if (legal_s) begin
                        // Re-seed on the current value, as from HUNT.
                        expected_s = seq_inc(din, MOD);
                        run_s      = RUNW'(1);
                    end else begin
                        state_s = HUNT;
                        run_s   = '0;
                    end
                end
                LOCKED: begin
                    // Flywheel: expected advances whether or not din matched.
                    expected_s = seq_inc(expected_r, MOD);
                    if (din == expected_r) begin
                        miss_s = '0;
                        wrap_s = (int'(din) == (MOD - 1));
                    end else begin
                        err_s = 1'b1;
                        if ((int'(miss_r) + 1) == UNLOCK_ERR) begin
                            state_s     = HUNT;
                            expected_s  = 3'd0;
                            miss_s      = '0;
                            run_s       = '0;
                            lock_loss_s = 1'b1;
                        end else begin
                            miss_s = miss_r + MISSW'(1);
                        end
                    end
                end
                default: begin
                    state_s    = HUNT;
                    expected_s = 3'd0;
                    run_s      = '0;
                    miss_s     = '0;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= HUNT;
            expected_r  <= 3'd0;
            run_r       <= '0;
            miss_r      <= '0;
            locked_r    <= 1'b0;
            err_r       <= 1'b0;
            wrap_r      <= 1'b0;
            lock_loss_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            expected_r  <= expected_s;
            run_r       <= run_s;
            miss_r      <= miss_s;
            locked_r    <= (state_s == LOCKED);
            err_r       <= err_s;
            wrap_r      <= wrap_s;
            lock_loss_r <= lock_loss_s;
        end
    end

    sat_counter #(.W(ERRW)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr_cnt),
        .inc   (err_s),
        .count (err_count)
    );

    assign locked   = locked_r;
    assign err      = err_r;
    assign wrap     = wrap_r;
    assign expected = expected_r;

`ifdef SEQ_CHECKER_STATS_EN
    sat_counter #(.W(16)) u_wrap_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr_cnt),
        .inc   (wrap_s),
        .count (wrap_count)
    );
    assign lock_loss = lock_loss_r;
`else
    logic unused_s;
    assign unused_s = lock_loss_r;
`endif

endmodule

// File: tb/tb_seq_checker.sv
// ---------------------------------------------------------------------------
// tb_seq_checker
// Directed and randomized stimulus for seq_checker, checked against a
// behavioural model of the lock/flywheel rules. A second instance with a
// 2-bit error counter exercises saturation.
// ---------------------------------------------------------------------------
module tb_seq_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] din = 3'd0;
    logic       din_valid = 1'b0;
    logic       clr_cnt = 1'b0;

    logic       locked, err, wrap;
    logic [2:0] expected;
    logic [7:0] err_count;
    logic       locked2, err2, wrap2;
    logic [2:0] expected2;
    logic [1:0] err_count2;
`ifdef SEQ_CHECKER_STATS_EN
    logic [15:0] wrap_count, wrap_count2;
    logic        lock_loss, lock_loss2;
`endif

    seq_checker dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clr_cnt(clr_cnt),
        .locked(locked), .err(err), .wrap(wrap), .expected(expected),
        .err_count(err_count)
`ifdef SEQ_CHECKER_STATS_EN
        , .wrap_count(wrap_count), .lock_loss(lock_loss)
`endif
    );

    seq_checker #(.ERRW(2)) dut2 (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clr_cnt(clr_cnt),
        .locked(locked2), .err(err2), .wrap(wrap2), .expected(expected2),
        .err_count(err_count2)
`ifdef SEQ_CHECKER_STATS_EN
        , .wrap_count(wrap_count2), .lock_loss(lock_loss2)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model: "in lock" flag, length of the current in-order run (0 = hunting),
    // consecutive misses, next expected value and the two error tallies.
    bit m_locked = 1'b0;
    int m_run = 0;
    int m_miss = 0;
    int m_exp = 0;
    bit m_err = 1'b0;
    bit m_wrap = 1'b0;
    int m_ec = 0;
    int m_ec2 = 0;

    task automatic chk(input string tag, input int obs, input int exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic model(input bit r, input bit v, input int d, input bit c);
        if (r) begin
            m_locked = 1'b0; m_run = 0; m_miss = 0; m_exp = 0;
            m_err = 1'b0; m_wrap = 1'b0; m_ec = 0; m_ec2 = 0;
            return;
        end
        m_err = 1'b0;
        m_wrap = 1'b0;
        if (v) begin
            if (m_locked) begin
                if (d == m_exp) begin
                    m_miss = 0;
                    m_wrap = (d == 5);
                    m_exp = (m_exp + 1) % 6;
                end else begin
                    m_err = 1'b1;
                    m_miss++;
                    m_exp = (m_exp + 1) % 6;
                    if (m_miss == 2) begin
                        m_locked = 1'b0; m_miss = 0; m_run = 0; m_exp = 0;
                    end
                end
            end else if (m_run > 0 && d == m_exp) begin
                m_exp = (m_exp + 1) % 6;
                m_run++;
                if (m_run == 3) begin
                    m_locked = 1'b1; m_miss = 0; m_run = 0;
                end
            end else if (d < 6) begin
                m_exp = (d + 1) % 6;
                m_run = 1;
            end else begin
                m_run = 0;
            end
        end
        if (c) begin
            m_ec = m_err ? 1 : 0;
            m_ec2 = m_err ? 1 : 0;
        end else if (m_err) begin
            if (m_ec < 255) m_ec++;
            if (m_ec2 < 3) m_ec2++;
        end
    endtask

    task automatic step(input bit r, input bit v, input int d, input bit c);
        rst = r;
        din_valid = v;
        din = 3'(d);
        clr_cnt = c;
        model(r, v, d, c);
        @(posedge clk);
        #1;
        chk("locked", int'(locked), int'(m_locked));
        chk("err", int'(err), int'(m_err));
        chk("wrap", int'(wrap), int'(m_wrap));
        chk("expected", int'(expected), m_exp);
        chk("err_count", int'(err_count), m_ec);
        chk("err_count_w2", int'(err_count2), m_ec2);
        chk("locked_w2", int'(locked2), int'(m_locked));
    endtask

    task automatic feed(input int d);
        step(1'b0, 1'b1, d, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, $urandom_range(0, 7), 1'b0);
    endtask

    initial begin
        // Reset state
        step(1'b1, 1'b0, 0, 1'b0);
        step(1'b1, 1'b1, 3, 1'b0);
        chk("reset_locked", int'(locked), 0);
        chk("reset_expected", int'(expected), 0);

        // 1: lock on 0,1,2
        feed(0); feed(1);
        chk("t1_not_yet_locked", int'(locked), 0);
        feed(2);
        chk("t1_locked", int'(locked), 1);
        chk("t1_expected", int'(expected), 3);

        // 2: 3,4,5,0 with a single wrap after 5
        feed(3); chk("t2_exp4", int'(expected), 4);
        feed(4); chk("t2_exp5", int'(expected), 5);
        feed(5); chk("t2_wrap", int'(wrap), 1);
        feed(0); chk("t2_wrap_off", int'(wrap), 0);
        chk("t2_exp1", int'(expected), 1);
        chk("t2_errcnt", int'(err_count), 0);

        // 3: illegal 7 while expecting 3, then 4
        feed(1); feed(2);
        feed(7);
        chk("t3_err", int'(err), 1);
        chk("t3_errcnt", int'(err_count), 1);
        feed(4);
        chk("t3_err_off", int'(err), 0);
        chk("t3_locked", int'(locked), 1);
        chk("t3_exp5", int'(expected), 5);

        // 4: two misses drop lock, then relock on 1,2,3
        feed(5); feed(0); feed(1); feed(2);
        feed(1);
        chk("t4_still_locked", int'(locked), 1);
        feed(1);
        chk("t4_err2", int'(err), 1);
        chk("t4_unlocked", int'(locked), 0);
        chk("t4_exp0", int'(expected), 0);
        chk("t4_errcnt", int'(err_count), 3);
        feed(1); feed(2); feed(3);
        chk("t4_relocked", int'(locked), 1);

        // 5: mid-sequence start with idle gaps, then illegal value in HUNT
        step(1'b1, 1'b0, 0, 1'b0);
        feed(4); idle(); feed(5); idle(); idle();
        chk("t5_gap_exp", int'(expected), 0);
        feed(0);
        chk("t5_locked", int'(locked), 1);
        chk("t5_exp1", int'(expected), 1);
        step(1'b1, 1'b0, 0, 1'b0);
        feed(6);
        chk("t5_hunt_locked", int'(locked), 0);
        chk("t5_hunt_err", int'(err), 0);

        // Randomized run: mostly in-order values, some corruption, clears, resets
        for (int i = 0; i < 400; i++) begin
            int d;
            bit v, c, r;
            v = ($urandom_range(0, 3) != 0);
            d = ($urandom_range(0, 9) < 7) ? m_exp : $urandom_range(0, 7);
            c = ($urandom_range(0, 24) == 0);
            r = ($urandom_range(0, 99) == 0);
            step(r, v, d, c);
        end

        // 6: 2-bit error counter saturation, clear-with-error, reset while locked
        step(1'b1, 1'b0, 0, 1'b0);
        feed(0); feed(1); feed(2);
        for (int i = 0; i < 5; i++) begin
            feed((m_exp + 3) % 6);
            feed(m_exp);
        end
        chk("t6_locked", int'(locked2), 1);
        chk("t6_saturated", int'(err_count2), 3);
        step(1'b0, 1'b1, (m_exp + 2) % 6, 1'b1);
        chk("t6_clr_err", int'(err_count2), 1);
        step(1'b0, 1'b0, 0, 1'b1);
        chk("t6_clr_only", int'(err_count2), 0);
        feed(m_exp);
        step(1'b1, 1'b1, m_exp, 1'b0);
        chk("t6_rst_locked", int'(locked2), 0);
        chk("t6_rst_err", int'(err2), 0);
        chk("t6_rst_wrap", int'(wrap2), 0);
        chk("t6_rst_exp", int'(expected2), 0);
        chk("t6_rst_cnt", int'(err_count2), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
